riscv_mem: RTL and testbench

// Memory stage of the RISC-V pipeline; consumes the EXU->MEM valid/ready interface and produces the MEM->WB result.
// Non-memory ops pass through with one register stage. Loads/stores run a single data-bus transaction and stall

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_lsu_align.sv | 65 ++++++
 rtl/riscv_mem.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_mem.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage.
//   - funct3 load/store width encodings (MEM_B/H/W/BU/HU)
//   - access size classes used by the lane logic
//   - mem_state_t: memory-stage FSM states
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    HOLD
  } mem_state_t;

  // Reduce funct3 to an access size; unknown encodings behave as a word.
  function automatic logic [1:0] mem_size(input logic [2:0] width);
    case (width)
      MEM_B, MEM_BU: mem_size = SZ_B;
      MEM_H, MEM_HU: mem_size = SZ_H;
      default:       mem_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic for the memory stage.
// Store side (from the incoming op):
//   st_width/st_addr/st_data -> st_sel (byte lanes), st_wdata (lane-replicated), misaligned
// Load side (from the captured op and the bus):
//   ld_width/ld_addr/ld_rdata -> ld_data (lane-extracted, sign/zero-extended)
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_width,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  output logic [3:0]  st_sel,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_width,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  st_size;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [31:0] ld_shifted;

  assign st_size = mem_size(st_width);
  assign ld_size = mem_size(ld_width);

  always_comb begin
    st_sel     = 4'b1111;
    misaligned = 1'b0;
    case (st_size)
      SZ_B: st_sel = 4'b0001 << st_addr;
      SZ_H: begin
        st_sel     = 4'b0011 << {st_addr[1], 1'b0};
        misaligned = st_addr[0];
      end
      default: misaligned = |st_addr;
    endcase
  end

  // Each byte lane carries the byte that would land there for the access size.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wlane
      assign st_wdata[8*gi +: 8] = (st_size == SZ_B) ? st_data[7:0] :
                                   (st_size == SZ_H) ? st_data[8*(gi%2) +: 8] :
                                                       st_data[8*gi +: 8];
    end
  endgenerate

  // BU/HU have bit 2 of funct3 set; for B/H it selects zero extension.
  assign ld_unsigned = ld_width[2];
  assign ld_shifted  = ld_rdata >> {ld_addr, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (ld_size)
      SZ_B: ld_data = {{24{ld_shifted[7] & ~ld_unsigned}}, ld_shifted[7:0]};
      SZ_H: ld_data = {{16{ld_shifted[15] & ~ld_unsigned}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/riscv_mem.sv
// Memory stage of the RISC-V pipeline.
// Non-memory ops pass through with one register stage. Loads/stores run one
// data-bus transaction and stall upstream until ack or timeout.
// Ports:
//   clk_i, reset_ni                      clock, async active-low reset
//   valid_i/ready_o, pc_i, rd_addr_i,
//   rd_data_i, mem_data_i, mem_valid_i,
//   mem_we_i, mem_width_i                EXU->MEM op
//   valid_o/ready_i, pc_o, rd_addr_o,
//   rd_data_o                            MEM->WB result
//   dbus_*                               data bus master (cyc held until ack/timeout)
//   mem_err_o                            1-cycle pulse: misaligned or bus timeout
//   hz_rd_addr_o                         rd of op held in stage, for hazard logic
module riscv_mem
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [29:0] pc_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_width_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [29:0] pc_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        dbus_cyc_o,
  output logic [29:0] dbus_addr_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_err_o,
  output logic [4:0]  hz_rd_addr_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  mem_state_t       state_reg, state_next;
  logic             valid_reg, valid_next;
  logic             cyc_reg, cyc_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [29:0] out_pc_reg, out_pc_next;
  logic [4:0]  out_rd_reg, out_rd_next;
  logic [31:0] out_data_reg, out_data_next;

  logic [29:0] op_pc_reg;
  logic [4:0]  op_rd_reg;
  logic [31:0] op_addr_reg;
  logic        op_we_reg;
  logic [2:0]  op_width_reg;
  logic [3:0]  op_sel_reg;
  logic [31:0] op_wdata_reg;

  logic        stage_ready;
  logic        accept;
  logic        capture;
  logic        timeout_hit;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;
  logic        misaligned;
  logic [31:0] ld_data;

  riscv_lsu_align u_align (
    .st_width   (mem_width_i),
    .st_addr    (rd_data_i[1:0]),
    .st_data    (mem_data_i),
    .st_sel     (st_sel),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_width   (op_width_reg),
    .ld_addr    (op_addr_reg[1:0]),
    .ld_rdata   (dbus_rdata_i),
    .ld_data    (ld_data)
  );

  assign stage_ready = (state_reg == IDLE) && (!valid_reg || ready_i);
  assign accept      = valid_i && stage_ready;

  // An ack arriving on the last allowed cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST) && !dbus_ack_i;

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    cyc_next      = cyc_reg;
    err_next      = 1'b0;
    cnt_next      = cnt_reg;
    out_pc_next   = out_pc_reg;
    out_rd_next   = out_rd_reg;
    out_data_next = out_data_reg;
    capture       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ready_i) begin
          valid_next = 1'b0;
        end
        if (accept) begin
          if (!mem_valid_i) begin
            valid_next    = 1'b1;
            out_pc_next   = pc_i;
            out_rd_next   = rd_addr_i;
            out_data_next = rd_data_i;
          end else if (misaligned) begin
            // Retire as a no-op so the pipeline keeps flowing.
            valid_next    = 1'b1;
            err_next      = 1'b1;
            out_pc_next   = pc_i;
            out_rd_next   = 5'd0;
            out_data_next = rd_data_i;
          end else begin
            capture    = 1'b1;
            cyc_next   = 1'b1;
            cnt_next   = '0;
            state_next = BUS;
          end
        end
      end

      BUS: begin
        if (dbus_ack_i || timeout_hit) begin
          cyc_next      = 1'b0;
          cnt_next      = '0;
          valid_next    = 1'b1;
          err_next      = !dbus_ack_i;
          out_pc_next   = op_pc_reg;
          out_rd_next   = (dbus_ack_i && !op_we_reg) ? op_rd_reg : 5'd0;
          out_data_next = (dbus_ack_i && !op_we_reg) ? ld_data : op_addr_reg;
          state_next    = ready_i ? IDLE : HOLD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      HOLD: begin
        if (ready_i) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      cyc_reg   <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      cyc_reg   <= cyc_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Data path registers carry no reset; their contents only matter when qualified.
  always_ff @(posedge clk_i) begin
    out_pc_reg   <= out_pc_next;
    out_rd_reg   <= out_rd_next;
    out_data_reg <= out_data_next;
    if (capture) begin
      op_pc_reg    <= pc_i;
      op_rd_reg    <= rd_addr_i;
      op_addr_reg  <= rd_data_i;
      op_we_reg    <= mem_we_i;
      op_width_reg <= mem_width_i;
      op_sel_reg   <= st_sel;
      op_wdata_reg <= st_wdata;
    end
  end

  assign ready_o      = stage_ready;
  assign valid_o      = valid_reg;
  assign pc_o         = out_pc_reg;
  assign rd_addr_o    = out_rd_reg;
  assign rd_data_o    = out_data_reg;
  assign mem_err_o    = err_reg;
  assign dbus_cyc_o   = cyc_reg;
  assign dbus_addr_o  = op_addr_reg[31:2];
  assign dbus_we_o    = op_we_reg;
  assign dbus_sel_o   = op_sel_reg;
  assign dbus_wdata_o = op_wdata_reg;

  // A load on the bus has a pending register write even though valid_o is low.
  assign hz_rd_addr_o = (state_reg == BUS && !op_we_reg) ? op_rd_reg :
                        (valid_reg ? out_rd_reg : 5'd0);

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem (TIMEOUT_CYCLES = 4).
// Stimulus pushes expected WB results and bus requests into queues; a WB
// monitor and a bus responder pop and compare independently.
module tb_riscv_mem;
  import riscv_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_i;
  logic        ready_o;
  logic [29:0] pc_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;
  logic        mem_we_i;
  logic [2:0]  mem_width_i;
  logic        valid_o;
  logic        ready_i;
  logic [29:0] pc_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        dbus_cyc_o;
  logic [29:0] dbus_addr_o;
  logic        dbus_we_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        mem_err_o;
  logic [4:0]  hz_rd_addr_o;

  riscv_mem #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
    .mem_we_i(mem_we_i), .mem_width_i(mem_width_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o),
    .dbus_cyc_o(dbus_cyc_o), .dbus_addr_o(dbus_addr_o), .dbus_we_o(dbus_we_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .mem_err_o(mem_err_o), .hz_rd_addr_o(hz_rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [29:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    bit          err;
  } wb_t;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  sel;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // cyc cycles without ack before the ack cycle; -1 = never
    bit          rst;     // transaction is cut short by reset
    logic [4:0]  hz;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- WB monitor ----------------
  initial begin : wb_monitor
    wb_t         cur;
    bit          prev_valid;
    bit          prev_xfer;
    logic [29:0] h_pc;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    prev_valid = 0;
    prev_xfer  = 0;
    h_pc = '0; h_rd = '0; h_data = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        prev_valid = 0;
        prev_xfer  = 0;
      end else begin
        if (valid_o && (!prev_valid || prev_xfer)) begin
          if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got pc=%h rd=%0d data=%h, want no result",
                     pc_o, rd_addr_o, rd_data_o);
          end else begin
            cur = wb_q.pop_front();
            chk($sformatf("wb%0d_pc", cur.id), {2'b00, pc_o}, {2'b00, cur.pc});
            chk($sformatf("wb%0d_rd", cur.id), {27'd0, rd_addr_o}, {27'd0, cur.rd});
            if (cur.chk_data) chk($sformatf("wb%0d_data", cur.id), rd_data_o, cur.data);
            chk($sformatf("wb%0d_err", cur.id), {31'd0, mem_err_o}, {31'd0, cur.err});
          end
        end else if (valid_o) begin
          chk("wb_hold_pc", {2'b00, pc_o}, {2'b00, h_pc});
          chk("wb_hold_rd_data", rd_data_o, h_data);
          chk("wb_hold_rd", {27'd0, rd_addr_o}, {27'd0, h_rd});
        end else if (mem_err_o !== 1'b0) begin
          chk("err_spurious", {31'd0, mem_err_o}, 32'd0);
        end
        prev_valid = valid_o;
        prev_xfer  = valid_o && ready_i;
        h_pc   = pc_o;
        h_rd   = rd_addr_o;
        h_data = rd_data_o;
      end
    end
  end

  // ---------------- bus responder ----------------
  initial begin : bus_responder
    bus_t        cur;
    bit          active;
    int          n;
    logic [29:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = '0;
    active = 0;
    n = 0;
    cur = '{30'd0, 4'd0, 1'b0, 32'd0, 32'd0, 0, 1'b0, 5'd0};
    a0 = '0; s0 = '0; w0 = '0;
    forever begin
      @(negedge clk_i);
      dbus_ack_i = 1'b0;
      if (!reset_ni) begin
        if (active && !cur.rst) chk("bus_reset_unexpected", 32'd1, 32'd0);
        active = 0;
      end else begin
        if (active && !dbus_cyc_o) begin
          active = 0;
          if (cur.delay < 0 && !cur.rst) begin
            chk("bus_timeout_len", n, TIMEOUT);
            // Late ack after the timeout; the stage must ignore it.
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = 32'h5A5A5A5A;
          end
        end else if (!active && dbus_cyc_o) begin
          if (bus_q.size() == 0) begin
            chk("bus_unexpected", 32'd1, 32'd0);
            cur = '{dbus_addr_o, dbus_sel_o, dbus_we_o, dbus_wdata_o, 32'd0, 0, 1'b0, hz_rd_addr_o};
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", {2'b00, dbus_addr_o}, {2'b00, cur.addr});
            chk("bus_sel", {28'd0, dbus_sel_o}, {28'd0, cur.sel});
            chk("bus_we", {31'd0, dbus_we_o}, {31'd0, cur.we});
            if (cur.we) chk("bus_wdata", dbus_wdata_o, cur.wdata);
            chk("bus_hz_rd", {27'd0, hz_rd_addr_o}, {27'd0, cur.hz});
            chk("bus_stall", {31'd0, ready_o}, 32'd0);
          end
          active = 1;
          n = 0;
          a0 = dbus_addr_o;
          s0 = dbus_sel_o;
          w0 = dbus_wdata_o;
        end
        if (active && dbus_cyc_o) begin
          n++;
          if (n > 1) begin
            chk("bus_stable", {dbus_sel_o, dbus_addr_o[27:0]}, {s0, a0[27:0]});
            if (dbus_wdata_o !== w0 || dbus_addr_o !== a0)
              chk("bus_stable_wdata", 32'd1, 32'd0);
          end
          if (cur.delay >= 0 && n == cur.delay + 1) begin
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = cur.rdata;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [29:0] pc, input logic [4:0] rd, input logic [31:0] data,
                      input logic [31:0] sdata, input logic mv, input logic we,
                      input logic [2:0] w);
    bit took;
    valid_i = 1'b1; pc_i = pc; rd_addr_i = rd; rd_data_i = data;
    mem_data_i = sdata; mem_valid_i = mv; mem_we_i = we; mem_width_i = w;
    took = 0;
    for (int i = 0; i < 50 && !took; i++) begin
      @(negedge clk_i);
      took = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    chk("accept", {31'd0, took}, 32'd1);
  endtask

  task automatic alu_op(input int id, input logic [29:0] pc, input logic [4:0] rd,
                        input logic [31:0] data);
    wb_q.push_back('{id, pc, rd, data, 1'b1, 1'b0});
    send(pc, rd, data, 32'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic mem_op(input int id, input logic [29:0] pc, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic we,
                        input logic [2:0] w, input logic [3:0] sel, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay, input logic [4:0] wb_rd,
                        input logic [31:0] wb_data, input bit chk_data, input bit err);
    bus_q.push_back('{addr[31:2], sel, we, wdata, rdata, delay, 1'b0, we ? 5'd0 : rd});
    wb_q.push_back('{id, pc, wb_rd, wb_data, chk_data, err});
    send(pc, rd, addr, sdata, 1'b1, we, w);
  endtask

  task automatic misaligned_op(input int id, input logic [29:0] pc, input logic [4:0] rd,
                               input logic [31:0] addr, input logic [2:0] w);
    wb_q.push_back('{id, pc, 5'd0, 32'd0, 1'b0, 1'b1});
    send(pc, rd, addr, 32'd0, 1'b1, 1'b0, w);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      done = (wb_q.size() == 0) && (bus_q.size() == 0) && !valid_o && !dbus_cyc_o;
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit seen;
    reset_ni = 1'b0;
    valid_i = 1'b0; pc_i = '0; rd_addr_i = '0; rd_data_i = '0; mem_data_i = '0;
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_width_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_cyc", {31'd0, dbus_cyc_o}, 32'd0);
    chk("rst_err", {31'd0, mem_err_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_hz", {27'd0, hz_rd_addr_o}, 32'd0);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ALU pass-through
    alu_op(1, 30'h10, 5'd5, 32'h0000_1234);
    wait_idle();

    // Back-to-back ALU ops at one per cycle
    for (int i = 0; i < 3; i++) begin
      wb_q.push_back('{10 + i, 30'h11 + 30'(i), 5'd6 + 5'(i), 32'hA0 + 32'(i), 1'b1, 1'b0});
      valid_i = 1'b1; pc_i = 30'h11 + 30'(i); rd_addr_i = 5'd6 + 5'(i);
      rd_data_i = 32'hA0 + 32'(i); mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_width_i = '0;
      @(negedge clk_i);
      chk("stream_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    wait_idle();

    // LB 0x103, ack in the 4th bus cycle (same cycle the timeout would hit)
    mem_op(2, 30'h20, 5'd9, 32'h103, 32'd0, 1'b0, MEM_B, 4'b1000, 32'd0,
           32'h8012_3456, 3, 5'd9, 32'hFFFF_FF80, 1'b1, 1'b0);
    wait_idle();

    // SH 0x102
    mem_op(3, 30'h21, 5'd10, 32'h102, 32'h0000_ABCD, 1'b1, MEM_H, 4'b1100, 32'hABCD_ABCD,
           32'd0, 1, 5'd0, 32'd0, 1'b0, 1'b0);
    wait_idle();

    // LW 0x101 misaligned
    misaligned_op(4, 30'h22, 5'd11, 32'h101, MEM_W);
    wait_idle();

    // LW with no ack: timeout, late ack ignored
    mem_op(5, 30'h23, 5'd12, 32'h100, 32'd0, 1'b0, MEM_W, 4'b1111, 32'd0,
           32'd0, -1, 5'd0, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // LW with ack on the timeout cycle
    mem_op(6, 30'h24, 5'd13, 32'h100, 32'd0, 1'b0, MEM_W, 4'b1111, 32'd0,
           32'hDEAD_BEEF, 3, 5'd13, 32'hDEAD_BEEF, 1'b1, 1'b0);
    wait_idle();

    // LHU 0x2 with WB backpressure for 3 cycles
    ready_i = 1'b0;
    mem_op(7, 30'h25, 5'd14, 32'h2, 32'd0, 1'b0, MEM_HU, 4'b1100, 32'd0,
           32'hBEEF_0000, 0, 5'd14, 32'h0000_BEEF, 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      seen = valid_o;
    end
    chk("hold_valid_seen", {31'd0, seen}, 32'd1);
    chk("hold_hz", {27'd0, hz_rd_addr_o}, 32'd14);
    repeat (3) @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    wait_idle();

    // LH sign-extend, LBU zero-extend
    mem_op(8, 30'h26, 5'd15, 32'h0, 32'd0, 1'b0, MEM_H, 4'b0011, 32'd0,
           32'h0000_8001, 0, 5'd15, 32'hFFFF_8001, 1'b1, 1'b0);
    wait_idle();
    mem_op(9, 30'h27, 5'd16, 32'h1, 32'd0, 1'b0, MEM_BU, 4'b0010, 32'd0,
           32'h0000_FF00, 2, 5'd16, 32'h0000_00FF, 1'b1, 1'b0);
    wait_idle();

    // SB 0x5, SW 0x8
    mem_op(10, 30'h28, 5'd1, 32'h5, 32'h1234_5678, 1'b1, MEM_B, 4'b0010, 32'h7878_7878,
           32'd0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
    wait_idle();
    mem_op(11, 30'h29, 5'd2, 32'h8, 32'hCAFE_F00D, 1'b1, MEM_W, 4'b1111, 32'hCAFE_F00D,
           32'd0, 1, 5'd0, 32'd0, 1'b0, 1'b0);
    wait_idle();

    // Unknown funct3 behaves as a word load
    mem_op(12, 30'h2A, 5'd17, 32'h10, 32'd0, 1'b0, 3'b011, 4'b1111, 32'd0,
           32'h1122_3344, 0, 5'd17, 32'h1122_3344, 1'b1, 1'b0);
    wait_idle();

    // LH 0x3 misaligned
    misaligned_op(13, 30'h2B, 5'd18, 32'h3, MEM_H);
    wait_idle();

    // Reset in the middle of a bus cycle
    bus_q.push_back('{30'h8, 4'b1111, 1'b0, 32'd0, 32'd0, -1, 1'b1, 5'd19});
    send(30'h2C, 5'd19, 32'h20, 32'd0, 1'b1, 1'b0, MEM_W);
    @(negedge clk_i);
    chk("midbus_cyc_high", {31'd0, dbus_cyc_o}, 32'd1);
    @(posedge clk_i);
    #3;
    reset_ni = 1'b0;
    #1;
    chk("midbus_rst_cyc", {31'd0, dbus_cyc_o}, 32'd0);
    chk("midbus_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("midbus_rst_ready", {31'd0, ready_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Recovery after reset
    alu_op(14, 30'h30, 5'd20, 32'h0000_0055);
    wait_idle();

    chk("wb_q_empty", wb_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
